core_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the single-issue RISC-V integer datapath. Owns the program counter and instruction register, fetches from instruction memory over a request/ready handshake, and presents the latched instruction to the opcode/funct decoder. Steps every instruction through FETCH, DECODE, EXECUTE and WRITEBACK, and gates the register-file write strobe to a single WRITEBACK cycle. Sits between instruction memory and the decoder/ALU/register-file datapath.

---
 rtl/core_sequencer_if.sv | 35 +++
 rtl/core_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer_if
// Purpose  : Instruction-memory fetch handshake between the sequencer and
//            instruction memory.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   imem_req    sequencer -> memory   fetch request, held until accepted
//   imem_addr   sequencer -> memory   32-bit fetch address (word aligned)
//   imem_ready  memory -> sequencer   fetch accepted, rdata valid same cycle
//   imem_rdata  memory -> sequencer   32-bit fetched instruction word
// Modports: master (sequencer side), slave (memory side)
// ============================================================================
interface core_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Purpose  : Multi-cycle instruction sequencer for a single-issue RISC-V
//            integer datapath. Owns PC and instruction register, fetches over
//            a request/ready handshake and steps each instruction through
//            FETCH, DECODE, EXECUTE and WRITEBACK (or TRAP on an unsupported
//            opcode).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   RESET_PC       PC value loaded on reset (low two bits forced to zero)
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   start          leave IDLE and begin fetching at current pc
//   halt_req       stop after the current instruction completes
//   imem           fetch handshake (core_sequencer_if.master)
//   instr          instruction register, to decoder / immediate logic
//   dec_reg_write  decoder write-enable for the current instruction
//   rf_we          register-file write strobe (WRITEBACK only)
//   pc             program counter
//   busy           high in every state except IDLE
//   illegal        one-cycle pulse in TRAP
//   retire_cnt     retired-instruction count
// Build option:
//   RETIRE_CNT_EN  when defined, retire_cnt is a 32-bit wrapping counter of
//                  WRITEBACK cycles; otherwise it is tied to zero.
// ============================================================================
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         start,
  input  wire logic         halt_req,
  core_sequencer_if.master  imem,
  output logic [31:0]       instr,
  input  wire logic         dec_reg_write,
  output logic              rf_we,
  output logic [31:0]       pc,
  output logic              busy,
  output logic              illegal,
  output logic [31:0]       retire_cnt
);

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0]  OPC_ITYPE  = 7'b0010011;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] PC_RESET_V = {RESET_PC[31:2], 2'b00};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t state;
  state_t next_state;
  logic   halt_pend;
  logic   halt_now;
  logic   opc_legal;

  // A halt requested in the very cycle an instruction completes still counts.
  assign halt_now  = halt_pend | halt_req;
  assign opc_legal = (instr[6:0] == OPC_RTYPE) || (instr[6:0] == OPC_ITYPE);

  assign imem.imem_addr = pc;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    next_state    = state;
    imem.imem_req = 1'b0;
    rf_we         = 1'b0;
    illegal       = 1'b0;
    busy          = 1'b1;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !halt_req) begin
          next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) begin
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        next_state = opc_legal ? S_EXECUTE : S_TRAP;
      end
      S_EXECUTE: begin
        next_state = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // Only same-cycle input-to-output path in the block.
        rf_we      = dec_reg_write;
        next_state = halt_now ? S_IDLE : S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        next_state = halt_now ? S_IDLE : S_FETCH;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Program counter and instruction register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= PC_RESET_V;
      instr <= NOP_INSTR;
    end else begin
      if (state == S_FETCH && imem.imem_ready) begin
        instr <= imem.imem_rdata;
      end
      // Modulo-2^32 add; the new pc is seen by the following FETCH.
      if (state == S_WRITEBACK || state == S_TRAP) begin
        pc <= pc + PC_STEP;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Halt pending: armed by halt_req outside IDLE, dropped when IDLE is entered
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_pend <= 1'b0;
    end else if (next_state == S_IDLE) begin
      halt_pend <= 1'b0;
    end else if (state != S_IDLE && halt_req) begin
      halt_pend <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Retired-instruction counter
  // --------------------------------------------------------------------------
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= 32'd0;
    end else if (state == S_WRITEBACK) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_sequencer
// Purpose  : Self-checking bench for core_sequencer. Two instances: one with
//            RESET_PC=0 and one with RESET_PC=32'hFFFF_FFFC for pc wrap.
//            Stimulus pushes expected completion records; per-instance
//            monitors pop and compare when rf_we or illegal is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

  localparam logic [31:0] PC1      = 32'hFFFF_FFFC;
  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_ADDI2  = 32'h00A0_0113;
  localparam logic [31:0] I_ADD    = 32'h0020_81B3;
  localparam logic [31:0] I_BEQ    = 32'h0000_0063;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, start0, start1, halt0, halt1, dec0, dec1;
  logic [31:0] instr0, instr1, pc0, pc1, ret0, ret1;
  logic        rf_we0, rf_we1, busy0, busy1, ill0, ill1;

  core_sequencer_if if0();
  core_sequencer_if if1();

  core_sequencer #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .halt_req(halt0), .imem(if0),
    .instr(instr0), .dec_reg_write(dec0), .rf_we(rf_we0), .pc(pc0),
    .busy(busy0), .illegal(ill0), .retire_cnt(ret0)
  );

  core_sequencer #(.RESET_PC(PC1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .halt_req(halt1), .imem(if1),
    .instr(instr1), .dec_reg_write(dec1), .rf_we(rf_we1), .pc(pc1),
    .busy(busy1), .illegal(ill1), .retire_cnt(ret1)
  );

  typedef struct {
    int          cyc;
    logic        trap;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [31:0] rm0 = 32'd0;
  logic [31:0] rm1 = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_ret(input logic [31:0] n);
    return CNT_EN ? n : 32'd0;
  endfunction

  // --------------------------------------------------------------------------
  // Monitors
  // --------------------------------------------------------------------------
  exp_t        e0, e1;
  bit          np0_chk = 1'b0, np1_chk = 1'b0;
  logic [31:0] np0, np1;

  always @(negedge clk) begin
    if (np0_chk) begin
      chk("dut0 pc after completion", pc0, np0);
      np0_chk = 1'b0;
    end
    if (rf_we0 === 1'b1 || ill0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0 unexpected event: rf_we %b illegal %b at cycle %0d, expected none",
                 rf_we0, ill0, cyc);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 completion cycle", cyc, e0.cyc);
        chk("dut0 rf_we", rf_we0, !e0.trap);
        chk("dut0 illegal", ill0, e0.trap);
        chk("dut0 pc at completion", pc0, e0.pc);
        chk("dut0 instr", instr0, e0.instr);
        chk("dut0 retire_cnt", ret0, e0.ret);
        np0     = e0.pc + 32'd4;
        np0_chk = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (np1_chk) begin
      chk("dut1 pc after completion", pc1, np1);
      np1_chk = 1'b0;
    end
    if (rf_we1 === 1'b1 || ill1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected event: rf_we %b illegal %b at cycle %0d, expected none",
                 rf_we1, ill1, cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 completion cycle", cyc, e1.cyc);
        chk("dut1 rf_we", rf_we1, !e1.trap);
        chk("dut1 illegal", ill1, e1.trap);
        chk("dut1 pc at completion", pc1, e1.pc);
        chk("dut1 instr", instr1, e1.instr);
        chk("dut1 retire_cnt", ret1, e1.ret);
        np1     = e1.pc + 32'd4;
        np1_chk = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  logic        s_req, s_busy, s_we, s_ill;
  logic [31:0] s_addr, s_pc, s_ret, s_instr;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int id, input logic st, input logic hl, input logic rdy,
                        input logic [31:0] word, input logic we);
    if (id == 0) begin
      start0 = st; halt0 = hl; if0.imem_ready = rdy; if0.imem_rdata = word; dec0 = we;
    end else begin
      start1 = st; halt1 = hl; if1.imem_ready = rdy; if1.imem_rdata = word; dec1 = we;
    end
  endtask

  task automatic sample(input int id);
    @(negedge clk);
    if (id == 0) begin
      s_req = if0.imem_req; s_addr = if0.imem_addr; s_busy = busy0; s_pc = pc0;
      s_ret = ret0; s_instr = instr0; s_we = rf_we0; s_ill = ill0;
    end else begin
      s_req = if1.imem_req; s_addr = if1.imem_addr; s_busy = busy1; s_pc = pc1;
      s_ret = ret1; s_instr = instr1; s_we = rf_we1; s_ill = ill1;
    end
  endtask

  task automatic check_reset(input int id, input logic [31:0] pcx);
    sample(id);
    chk("reset busy", s_busy, 1'b0);
    chk("reset imem_req", s_req, 1'b0);
    chk("reset rf_we", s_we, 1'b0);
    chk("reset illegal", s_ill, 1'b0);
    chk("reset pc", s_pc, pcx);
    chk("reset imem_addr", s_addr, pcx);
    chk("reset instr", s_instr, NOP);
    chk("reset retire_cnt", s_ret, 32'd0);
  endtask

  // Runs one instruction. Returns one cycle after WRITEBACK/TRAP.
  task automatic issue(input int id, input logic [31:0] word, input logic trap, input int waits,
                       input logic hl, input logic we, input logic from_idle,
                       input logic [31:0] pcx);
    exp_t e;
    int   f;
    if (from_idle) begin
      set_in(id, 1'b1, 1'b0, 1'b0, word, we);
      tick;
    end
    f = cyc;
    set_in(id, 1'b0, hl, (waits == 0), word, we);
    e.cyc   = trap ? (f + waits + 2) : (f + waits + 3);
    e.trap  = trap;
    e.pc    = pcx;
    e.instr = word;
    e.ret   = exp_ret(id == 0 ? rm0 : rm1);
    if (trap || we) begin
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
    if (!trap) begin
      if (id == 0) rm0 = rm0 + 32'd1;
      else         rm1 = rm1 + 32'd1;
    end
    for (int i = 0; i <= waits; i++) begin
      sample(id);
      chk("fetch imem_req", s_req, 1'b1);
      chk("fetch imem_addr", s_addr, pcx);
      tick;
      set_in(id, 1'b0, 1'b0, (i == waits - 1), word, we);
    end
    tick;
    tick;
    if (!trap) tick;
    if (hl) begin
      sample(id);
      chk("halted busy", s_busy, 1'b0);
      chk("halted imem_req", s_req, 1'b0);
      chk("halted pc", s_pc, pcx + 32'd4);
      chk("halted retire_cnt", s_ret, exp_ret(id == 0 ? rm0 : rm1));
      tick;
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    set_in(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick; tick; tick;
    check_reset(0, 32'h0000_0000);
    check_reset(1, PC1);
    rst0 = 1'b0; rst1 = 1'b0;
    tick;

    // ADDI, zero-wait memory, pc 0 -> 4
    issue(0, I_ADDI, 1'b0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0000);

    // Back-to-back: ADD with 3 wait cycles, then illegal opcode into TRAP
    issue(0, I_ADD, 1'b0, 3, 1'b0, 1'b1, 1'b1, 32'h0000_0004);
    issue(0, I_BEQ, 1'b1, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0008);

    // halt_req during a FETCH wait
    issue(0, I_ADDI, 1'b0, 3, 1'b1, 1'b1, 1'b1, 32'h0000_000C);

    // start with halt_req in IDLE stays IDLE
    set_in(0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    tick;
    set_in(0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    sample(0);
    chk("start+halt busy", s_busy, 1'b0);
    chk("start+halt imem_req", s_req, 1'b0);
    tick;
    sample(0);
    chk("start+halt busy later", s_busy, 1'b0);
    tick;

    // Decoder write-enable low: WRITEBACK without a strobe, still retires
    issue(0, I_ADDI2, 1'b0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0010);

    // Reset during a FETCH wait drops the request
    set_in(0, 1'b1, 1'b0, 1'b0, I_ADDI, 1'b1);
    tick;
    set_in(0, 1'b0, 1'b0, 1'b0, I_ADDI, 1'b1);
    sample(0);
    chk("fetch wait imem_req", s_req, 1'b1);
    rst0 = 1'b1;
    tick;
    check_reset(0, 32'h0000_0000);
    rst0 = 1'b0;
    rm0  = 32'd0;
    tick;

    // pc wrap from 32'hFFFF_FFFC
    issue(1, I_ADD, 1'b0, 0, 1'b1, 1'b1, 1'b1, PC1);

    // Reset in EXECUTE
    set_in(1, 1'b1, 1'b0, 1'b0, I_ADD, 1'b1);
    tick;
    set_in(1, 1'b0, 1'b0, 1'b1, I_ADD, 1'b1);
    tick;
    set_in(1, 1'b0, 1'b0, 1'b0, I_ADD, 1'b1);
    tick;
    sample(1);
    chk("execute busy", s_busy, 1'b1);
    chk("execute rf_we", s_we, 1'b0);
    rst1 = 1'b1;
    tick;
    check_reset(1, PC1);
    rst1 = 1'b0;
    rm1  = 32'd0;
    tick; tick; tick;

    chk("dut0 scoreboard drained", q0.size(), 32'd0);
    chk("dut1 scoreboard drained", q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
